// File: rtl/ysyx_bus_pkg.sv
// Shared types for the read-channel arbiter: FSM states, owner encoding and
// the AXI response code treated as success.
package ysyx_bus_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the
// requester that did not win last time (last: 0 = req[0], 1 = req[1]) wins.
module ysyx_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_bus_rd_arb.sv
// Shares one AXI4 AR/R channel between the IFU and LSU with a single
// outstanding transaction, round-robin arbitration and an IFU bus lock.
module ysyx_bus_rd_arb
  import ysyx_bus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ifu_arvalid,
  input  logic [XLEN-1:0] ifu_araddr,
  input  logic [2:0]      ifu_arsize,
  input  logic [7:0]      ifu_arlen,
  input  logic [1:0]      ifu_arburst,
  output logic            ifu_arready,
  input  logic            ifu_lock,
  output logic [XLEN-1:0] ifu_rdata,
  output logic            ifu_rvalid,
  output logic            ifu_rlast,
  output logic [1:0]      ifu_rresp,
  input  logic            ifu_rready,
  input  logic            lsu_arvalid,
  input  logic [XLEN-1:0] lsu_araddr,
  input  logic [2:0]      lsu_arsize,
  input  logic [7:0]      lsu_arlen,
  input  logic [1:0]      lsu_arburst,
  output logic            lsu_arready,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_rvalid,
  output logic            lsu_rlast,
  output logic [1:0]      lsu_rresp,
  input  logic            lsu_rready,
  output logic            io_master_arvalid,
  output logic [XLEN-1:0] io_master_araddr,
  output logic [2:0]      io_master_arsize,
  output logic [7:0]      io_master_arlen,
  output logic [1:0]      io_master_arburst,
  output logic [3:0]      io_master_arid,
  input  logic            io_master_arready,
  input  logic            io_master_rvalid,
  input  logic [XLEN-1:0] io_master_rdata,
  input  logic            io_master_rlast,
  input  logic [1:0]      io_master_rresp,
  input  logic [3:0]      io_master_rid,
  output logic            io_master_rready,
  output logic            out_err_resp,
  output logic            out_err_len,
  output logic            out_busy
);

  arb_state_t state_reg, state_next;
  arb_owner_t owner_reg, owner_next;
  arb_owner_t last_gnt_reg, last_gnt_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       err_len_reg, err_len_next;
  logic       err_resp_reg, err_resp_next;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       own_lsu;
  logic       own_rready;
  logic       beat_fire;
  logic       unused_rid;

  // The lock only gates new LSU grants; an LSU burst already granted runs on.
  assign req = {lsu_arvalid && !ifu_lock, ifu_arvalid};

  ysyx_rr_pick2 u_pick (
    .req  (req),
    .last (last_gnt_reg == OWN_LSU),
    .gnt  (gnt)
  );

  assign own_lsu    = (owner_reg == OWN_LSU);
  assign own_rready = own_lsu ? lsu_rready : ifu_rready;
  assign beat_fire  = (state_reg == DATA) && io_master_rvalid && own_rready;
  assign unused_rid = ^io_master_rid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= OWN_IFU;
      last_gnt_reg <= OWN_LSU;
      cnt_reg      <= 8'd0;
      err_len_reg  <= 1'b0;
      err_resp_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_gnt_reg <= last_gnt_next;
      cnt_reg      <= cnt_next;
      err_len_reg  <= err_len_next;
      err_resp_reg <= err_resp_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    last_gnt_next = last_gnt_reg;
    cnt_next      = cnt_reg;
    err_len_next  = err_len_reg;
    err_resp_next = err_resp_reg;
    case (state_reg)
      IDLE: begin
        if (gnt[0]) begin
          owner_next = OWN_IFU;
          state_next = ADDR;
        end else if (gnt[1]) begin
          owner_next = OWN_LSU;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (io_master_arready) begin
          cnt_next   = own_lsu ? lsu_arlen : ifu_arlen;
          state_next = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          if (io_master_rresp != AXI_RESP_OKAY) err_resp_next = 1'b1;
          // Counter holds beats still owed after this one; rlast must line up with zero.
          if (io_master_rlast != (cnt_reg == 8'd0)) err_len_next = 1'b1;
          if (cnt_reg != 8'd0) cnt_next = cnt_reg - 8'd1;
          if (io_master_rlast || (cnt_reg == 8'd0)) begin
            state_next    = IDLE;
            last_gnt_next = owner_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arsize  = 3'd0;
    io_master_arlen   = 8'd0;
    io_master_arburst = 2'd0;
    ifu_arready       = 1'b0;
    lsu_arready       = 1'b0;
    io_master_rready  = 1'b0;
    ifu_rvalid        = 1'b0;
    ifu_rdata         = '0;
    ifu_rlast         = 1'b0;
    ifu_rresp         = 2'd0;
    lsu_rvalid        = 1'b0;
    lsu_rdata         = '0;
    lsu_rlast         = 1'b0;
    lsu_rresp         = 2'd0;
    if (state_reg == ADDR) begin
      io_master_arvalid = 1'b1;
      io_master_araddr  = own_lsu ? lsu_araddr  : ifu_araddr;
      io_master_arsize  = own_lsu ? lsu_arsize  : ifu_arsize;
      io_master_arlen   = own_lsu ? lsu_arlen   : ifu_arlen;
      io_master_arburst = own_lsu ? lsu_arburst : ifu_arburst;
      ifu_arready       = !own_lsu && io_master_arready;
      lsu_arready       = own_lsu && io_master_arready;
    end
    if (state_reg == DATA) begin
      io_master_rready = own_rready;
      if (own_lsu) begin
        lsu_rvalid = io_master_rvalid;
        lsu_rdata  = io_master_rdata;
        lsu_rlast  = io_master_rlast;
        lsu_rresp  = io_master_rresp;
      end else begin
        ifu_rvalid = io_master_rvalid;
        ifu_rdata  = io_master_rdata;
        ifu_rlast  = io_master_rlast;
        ifu_rresp  = io_master_rresp;
      end
    end
  end

  assign io_master_arid = 4'd0;
  assign out_err_resp   = err_resp_reg;
  assign out_err_len    = err_len_reg;
  assign out_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ysyx_bus_rd_arb.sv
// Bench for ysyx_bus_rd_arb: directed scenarios plus a random phase, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_ysyx_bus_rd_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_arvalid = 1'b0, lsu_arvalid = 1'b0;
  logic [31:0] ifu_araddr = '0, lsu_araddr = '0;
  logic [2:0]  ifu_arsize = '0, lsu_arsize = '0;
  logic [7:0]  ifu_arlen = '0, lsu_arlen = '0;
  logic [1:0]  ifu_arburst = '0, lsu_arburst = '0;
  logic        ifu_arready, lsu_arready;
  logic        ifu_lock = 1'b0;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic        ifu_rvalid, ifu_rlast, lsu_rvalid, lsu_rlast;
  logic [1:0]  ifu_rresp, lsu_rresp;
  logic        ifu_rready = 1'b1, lsu_rready = 1'b1;
  logic        io_master_arvalid;
  logic [31:0] io_master_araddr;
  logic [2:0]  io_master_arsize;
  logic [7:0]  io_master_arlen;
  logic [1:0]  io_master_arburst;
  logic [3:0]  io_master_arid;
  logic        io_master_arready = 1'b1;
  logic        io_master_rvalid = 1'b0;
  logic [31:0] io_master_rdata = '0;
  logic        io_master_rlast = 1'b0;
  logic [1:0]  io_master_rresp = '0;
  logic [3:0]  io_master_rid = '0;
  logic        io_master_rready;
  logic        out_err_resp, out_err_len, out_busy;

  ysyx_bus_rd_arb #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize),
    .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst), .ifu_arready(ifu_arready),
    .ifu_lock(ifu_lock), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
    .ifu_rlast(ifu_rlast), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
    .lsu_arlen(lsu_arlen), .lsu_arburst(lsu_arburst), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_rlast(lsu_rlast),
    .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
    .io_master_arvalid(io_master_arvalid), .io_master_araddr(io_master_araddr),
    .io_master_arsize(io_master_arsize), .io_master_arlen(io_master_arlen),
    .io_master_arburst(io_master_arburst), .io_master_arid(io_master_arid),
    .io_master_arready(io_master_arready), .io_master_rvalid(io_master_rvalid),
    .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast),
    .io_master_rresp(io_master_rresp), .io_master_rid(io_master_rid),
    .io_master_rready(io_master_rready),
    .out_err_resp(out_err_resp), .out_err_len(out_err_len), .out_busy(out_busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  function automatic void chk32(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk1(string nm, logic act, logic exp);
    chk32(nm, {31'd0, act}, {31'd0, exp});
  endfunction

  // Reference: one transaction record; owner/last use 1 = LSU.
  bit m_busy = 0, m_ar = 0, m_owner = 0, m_last = 1;
  bit m_err_len = 0, m_err_resp = 0;
  int m_len = 0, m_k = 0;

  always @(negedge clock) begin
    bit ci, cl, o_rr, e_arv, e_dat;
    if (chk_en) begin
      o_rr  = m_owner ? lsu_rready : ifu_rready;
      e_arv = m_busy && !m_ar;
      e_dat = m_busy && m_ar;
      chk1("busy", out_busy, m_busy);
      chk1("m_arvalid", io_master_arvalid, e_arv);
      chk32("m_arid", {28'd0, io_master_arid}, 32'd0);
      if (e_arv) begin
        chk1("proto_arvalid_held", m_owner ? lsu_arvalid : ifu_arvalid, 1'b1);
        chk32("m_araddr", io_master_araddr, m_owner ? lsu_araddr : ifu_araddr);
        chk32("m_arlen", {24'd0, io_master_arlen}, {24'd0, m_owner ? lsu_arlen : ifu_arlen});
        chk32("m_arsize", {29'd0, io_master_arsize}, {29'd0, m_owner ? lsu_arsize : ifu_arsize});
        chk32("m_arburst", {30'd0, io_master_arburst}, {30'd0, m_owner ? lsu_arburst : ifu_arburst});
      end
      chk1("ifu_arready", ifu_arready, e_arv && !m_owner && io_master_arready);
      chk1("lsu_arready", lsu_arready, e_arv && m_owner && io_master_arready);
      chk1("m_rready", io_master_rready, e_dat && o_rr);
      chk1("ifu_rvalid", ifu_rvalid, e_dat && !m_owner && io_master_rvalid);
      chk1("lsu_rvalid", lsu_rvalid, e_dat && m_owner && io_master_rvalid);
      if (e_dat) begin
        chk32("own_rdata", m_owner ? lsu_rdata : ifu_rdata, io_master_rdata);
        chk1("own_rlast", m_owner ? lsu_rlast : ifu_rlast, io_master_rlast);
        chk32("own_rresp", {30'd0, m_owner ? lsu_rresp : ifu_rresp}, {30'd0, io_master_rresp});
      end
      chk1("err_len", out_err_len, m_err_len);
      chk1("err_resp", out_err_resp, m_err_resp);
      // Advance the model to what must hold after the coming edge.
      if (reset) begin
        m_busy = 0; m_ar = 0; m_last = 1; m_err_len = 0; m_err_resp = 0;
      end else if (!m_busy) begin
        ci = ifu_arvalid;
        cl = lsu_arvalid && !ifu_lock;
        if (ci || cl) begin
          m_busy = 1; m_ar = 0;
          m_owner = (ci && cl) ? !m_last : cl;
        end
      end else if (!m_ar) begin
        if (io_master_arready) begin
          m_ar = 1; m_k = 0;
          m_len = int'(m_owner ? lsu_arlen : ifu_arlen);
        end
      end else if (io_master_rvalid && o_rr) begin
        if (io_master_rresp != 2'b00) m_err_resp = 1;
        if (io_master_rlast ? (m_k != m_len) : (m_k >= m_len)) m_err_len = 1;
        if (io_master_rlast || m_k >= m_len) begin
          m_busy = 0; m_last = m_owner;
        end else begin
          m_k++;
        end
      end
    end
  end

  // Bench-side requesters and slave.
  bit ifu_pend = 0, lsu_pend = 0, rnd = 0;
  bit s_act = 0;
  int s_idx = 0;
  logic [7:0] s_len = '0;
  int fault = 0;  // 0 normal, 1 rlast on first beat, 2 rlast never
  logic [1:0] beat_resp = 2'b00;
  logic [31:0] beat_data = '0;
  int dut_gnt[$];
  logic snap_arvalid, snap_ifu_arready, snap_lsu_arready, snap_ifu_rvalid, snap_lsu_rvalid;
  logic snap_ifu_rlast, snap_rready, snap_busy, snap_err_len, snap_err_resp;
  logic [31:0] snap_araddr, snap_ifu_rdata;
  logic [1:0] snap_lsu_rresp;

  task automatic step();
    bit ia, la, arh, rh, lastv, rst_s;
    logic [7:0] lenv;
    @(negedge clock);
    snap_arvalid = io_master_arvalid; snap_araddr = io_master_araddr;
    snap_ifu_arready = ifu_arready; snap_lsu_arready = lsu_arready;
    snap_ifu_rvalid = ifu_rvalid; snap_lsu_rvalid = lsu_rvalid;
    snap_ifu_rdata = ifu_rdata; snap_ifu_rlast = ifu_rlast; snap_lsu_rresp = lsu_rresp;
    snap_rready = io_master_rready; snap_busy = out_busy;
    snap_err_len = out_err_len; snap_err_resp = out_err_resp;
    ia = ifu_arready; la = lsu_arready;
    arh = io_master_arvalid && io_master_arready;
    rh = io_master_rvalid && io_master_rready;
    lastv = io_master_rlast; lenv = io_master_arlen; rst_s = reset;
    if (ia || la) begin
      dut_gnt.push_back(la ? 1 : 0);
      $display("txn %s addr=%h len=%0d t=%0t", la ? "LSU" : "IFU", io_master_araddr, io_master_arlen, $time);
    end
    @(posedge clock); #1;
    if (rst_s) begin
      ifu_pend = 0; lsu_pend = 0; s_act = 0;
    end else begin
      if (ia) ifu_pend = 0;
      if (la) lsu_pend = 0;
      if (arh) begin
        s_act = 1; s_idx = 0; s_len = lenv;
        if (rnd) fault = ($urandom_range(0, 9) == 0) ? 1 : ($urandom_range(0, 9) == 0) ? 2 : 0;
      end else if (rh) begin
        if (lastv || s_idx >= int'(s_len)) s_act = 0;
        else s_idx++;
      end
    end
    if (rnd) begin
      if (!ifu_pend && $urandom_range(0, 3) == 0) begin
        ifu_araddr = $urandom; ifu_arlen = 8'($urandom_range(0, 3));
        ifu_arsize = 3'($urandom_range(0, 2)); ifu_arburst = 2'($urandom_range(0, 2)); ifu_pend = 1;
      end
      if (!lsu_pend && $urandom_range(0, 3) == 0) begin
        lsu_araddr = $urandom; lsu_arlen = 8'($urandom_range(0, 3));
        lsu_arsize = 3'($urandom_range(0, 2)); lsu_arburst = 2'($urandom_range(0, 2)); lsu_pend = 1;
      end
      if ($urandom_range(0, 7) == 0) ifu_lock = ~ifu_lock;
      ifu_rready = ($urandom_range(0, 3) != 0);
      lsu_rready = ($urandom_range(0, 3) != 0);
      io_master_arready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 699) == 0);
      beat_resp = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      beat_data = $urandom;
    end
    ifu_arvalid = ifu_pend;
    lsu_arvalid = lsu_pend;
    io_master_rvalid = s_act && (!rnd || $urandom_range(0, 3) != 0);
    io_master_rlast = (fault == 1) ? 1'b1 : (fault == 2) ? 1'b0 : (s_idx == int'(s_len));
    io_master_rdata = beat_data + 32'(s_idx);
    io_master_rresp = s_act ? beat_resp : 2'b00;
    io_master_rid = 4'($urandom);
  endtask

  task automatic issue_ifu(logic [31:0] a, logic [7:0] l);
    ifu_araddr = a; ifu_arlen = l; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
    ifu_pend = 1; ifu_arvalid = 1'b1;
  endtask

  task automatic issue_lsu(logic [31:0] a, logic [7:0] l);
    lsu_araddr = a; lsu_arlen = l; lsu_arsize = 3'd2; lsu_arburst = 2'b01;
    lsu_pend = 1; lsu_arvalid = 1'b1;
  endtask

  task automatic run_until_idle(string nm, int budget);
    int n = 0;
    bit pending;
    do begin
      step(); n++;
      pending = ifu_pend || lsu_pend || s_act || snap_busy;
    end while (pending && n < budget);
    chk1(nm, pending, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4] = '{0, 1, 0, 1};
    bit seen;
    @(posedge clock); #1;
    chk_en = 1'b1;
    step(); step();
    reset = 1'b0;
    chk1("rst_busy", snap_busy, 1'b0);
    chk1("rst_arvalid", snap_arvalid, 1'b0);

    // Single IFU fetch.
    beat_data = 32'hDEAD_BEEF;
    issue_ifu(32'h3000_0000, 8'd0);
    step(); chk1("t1_no_ar_yet", snap_arvalid, 1'b0);
    step(); chk1("t1_arvalid", snap_arvalid, 1'b1);
    chk1("t1_ifu_arready", snap_ifu_arready, 1'b1);
    chk32("t1_araddr", snap_araddr, 32'h3000_0000);
    step(); chk1("t1_ifu_rvalid", snap_ifu_rvalid, 1'b1);
    chk32("t1_ifu_rdata", snap_ifu_rdata, 32'hDEAD_BEEF);
    chk1("t1_ifu_rlast", snap_ifu_rlast, 1'b1);
    chk1("t1_lsu_rvalid", snap_lsu_rvalid, 1'b0);
    step(); chk1("t1_idle", snap_busy, 1'b0);

    // Simultaneous requests alternate from reset.
    apply_reset();
    dut_gnt.delete();
    for (int r = 0; r < 2; r++) begin
      issue_ifu(32'h1000_0000 + 32'(r), 8'd0);
      issue_lsu(32'h2000_0000 + 32'(r), 8'd1);
      run_until_idle("t2_idle", 50);
    end
    chk32("t2_grant_count", 32'(dut_gnt.size()), 32'd4);
    for (int i = 0; i < 4 && i < dut_gnt.size(); i++) chk32("t2_grant_order", 32'(dut_gnt[i]), 32'(order[i]));

    // IFU lock holds off the LSU.
    ifu_lock = 1'b1;
    issue_lsu(32'h4000_0010, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("t3_locked_arvalid", snap_arvalid, 1'b0);
      chk1("t3_locked_arready", snap_lsu_arready, 1'b0);
    end
    ifu_lock = 1'b0;
    step(); chk1("t3_grant_cycle", snap_arvalid, 1'b0);
    step(); chk1("t3_lsu_ar", snap_lsu_arready, 1'b1);
    chk32("t3_lsu_addr", snap_araddr, 32'h4000_0010);
    run_until_idle("t3_idle", 20);

    // IFU burst with backpressure on the first beat.
    beat_data = 32'h1111_0000;
    ifu_rready = 1'b0;
    issue_ifu(32'hA000_0000, 8'd1);
    step(); step(); chk1("t4_arvalid", snap_arvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("t4_stall_rvalid", snap_ifu_rvalid, 1'b1);
      chk1("t4_stall_rready", snap_rready, 1'b0);
    end
    ifu_rready = 1'b1;
    step(); chk32("t4_beat0", snap_ifu_rdata, 32'h1111_0000);
    chk1("t4_beat0_last", snap_ifu_rlast, 1'b0);
    chk1("t4_beat0_rready", snap_rready, 1'b1);
    step(); chk32("t4_beat1", snap_ifu_rdata, 32'h1111_0001);
    chk1("t4_beat1_last", snap_ifu_rlast, 1'b1);
    step(); chk1("t4_idle", snap_busy, 1'b0);
    chk1("t4_err_len", snap_err_len, 1'b0);

    // Early rlast flags a length error, sticky across a clean burst.
    fault = 1;
    issue_ifu(32'h8000_0000, 8'd1);
    run_until_idle("t5_idle", 20);
    fault = 0;
    chk1("t5_err_len", snap_err_len, 1'b1);
    issue_lsu(32'h8000_0100, 8'd0);
    run_until_idle("t5_idle2", 20);
    chk1("t5_err_len_sticky", snap_err_len, 1'b1);

    // SLVERR on an LSU load.
    beat_resp = 2'b10;
    issue_lsu(32'h8000_1000, 8'd0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = snap_lsu_rvalid;
    end
    chk1("t6_lsu_beat_seen", seen, 1'b1);
    chk32("t6_lsu_rresp", {30'd0, snap_lsu_rresp}, 32'd2);
    beat_resp = 2'b00;
    step(); chk1("t6_err_resp", snap_err_resp, 1'b1);
    run_until_idle("t6_idle", 20);

    // Reset while in DATA.
    ifu_rready = 1'b0;
    issue_ifu(32'h3000_0040, 8'd3);
    step(); step(); step();
    chk1("t7_in_data", snap_busy, 1'b1);
    reset = 1'b1;
    step(); step();
    chk1("t7_busy", snap_busy, 1'b0);
    chk1("t7_arvalid", snap_arvalid, 1'b0);
    chk1("t7_rready", snap_rready, 1'b0);
    chk1("t7_ifu_rvalid", snap_ifu_rvalid, 1'b0);
    chk32("t7_ifu_rdata", snap_ifu_rdata, 32'd0);
    chk1("t7_err_len", snap_err_len, 1'b0);
    chk1("t7_err_resp", snap_err_resp, 1'b0);
    reset = 1'b0;
    ifu_rready = 1'b1;

    // Random traffic against the model.
    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    reset = 1'b0; ifu_lock = 1'b0; fault = 0; beat_resp = 2'b00;
    ifu_rready = 1'b1; lsu_rready = 1'b1; io_master_arready = 1'b1;
    run_until_idle("drain_idle", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
